// File: rtl/sparc_windowed_regfile.sv
// SPARC windowed integer register file: globals plus NWINDOWS overlapping windows,
// three combinational read ports, one write port, SAVE/RESTORE with WIM traps.
module sparc_windowed_regfile #(
    parameter int DATA_W   = 32,
    parameter int NWINDOWS = 8,
    parameter int CWP_W    = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          RA,
    input  logic [4:0]          RB,
    input  logic [4:0]          RD,
    input  logic [4:0]          RW,
    input  logic [DATA_W-1:0]   PW,
    input  logic                LE,
    input  logic                save,
    input  logic                restore,
    input  logic                cwp_we,
    input  logic [CWP_W-1:0]    cwp_in,
    input  logic                wim_we,
    input  logic [NWINDOWS-1:0] wim_in,
    output logic [DATA_W-1:0]   PA,
    output logic [DATA_W-1:0]   PB,
    output logic [DATA_W-1:0]   PD,
    output logic [CWP_W-1:0]    cwp,
    output logic [NWINDOWS-1:0] wim,
    output logic                ovf_trap,
    output logic                unf_trap,
    output logic                op_err
);
    localparam int NPHYS  = 8 + 16 * NWINDOWS;
    localparam int PIDX_W = $clog2(NPHYS);
    localparam logic [CWP_W-1:0] CWP_MAX = CWP_W'(NWINDOWS - 1);

    logic [DATA_W-1:0]   mem_q [NPHYS];
    logic [CWP_W-1:0]    cwp_q, cwp_d;
    logic [NWINDOWS-1:0] wim_q, wim_d;
    logic                ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
    logic [CWP_W-1:0]    sv_next, rs_next;
    logic                wr_en;
    logic [PIDX_W-1:0]   wr_idx;

    // The ins of window w alias the outs of window w+1 (mod NWINDOWS).
    function automatic logic [PIDX_W-1:0] phys(input logic [4:0] r, input logic [CWP_W-1:0] w);
        int ri, wi, base;
        ri = int'(r);
        wi = int'(w);
        if (ri < 8)       base = ri;
        else if (ri < 24) base = 8 + 16 * wi + (ri - 8);
        else              base = 8 + 16 * ((wi == NWINDOWS - 1) ? 0 : wi + 1) + (ri - 24);
        return PIDX_W'(base);
    endfunction

    function automatic logic [DATA_W-1:0] rd_port(input logic [4:0] r);
        logic [PIDX_W-1:0] idx;
        idx = phys(r, cwp_q);
        if (r == 5'd0)                return '0;
        if (wr_en && (wr_idx == idx)) return PW;
        return mem_q[idx];
    endfunction

    assign wr_en  = LE && (RW != 5'd0);
    assign wr_idx = phys(RW, cwp_q);

    always_comb begin
        PA = rd_port(RA);
        PB = rd_port(RB);
        PD = rd_port(RD);
    end

    // Storage is never cleared; a write pending while reset is low is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n && wr_en) mem_q[wr_idx] <= PW;
    end

    assign sv_next = (cwp_q == '0)      ? CWP_MAX : cwp_q - 1'b1;
    assign rs_next = (cwp_q == CWP_MAX) ? '0      : cwp_q + 1'b1;

    always_comb begin
        cwp_d = cwp_q;
        wim_d = wim_we ? wim_in : wim_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        err_d = 1'b0;
        if (cwp_we) begin
            cwp_d = (cwp_in > CWP_MAX) ? CWP_MAX : cwp_in;
        end else if (save && restore) begin
            err_d = 1'b1;
        end else if (save) begin
            if (wim_q[sv_next]) ovf_d = 1'b1;
            else                cwp_d = sv_next;
        end else if (restore) begin
            if (wim_q[rs_next]) unf_d = 1'b1;
            else                cwp_d = rs_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cwp_q <= '0;
            wim_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cwp_q <= cwp_d;
            wim_q <= wim_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            err_q <= err_d;
        end
    end

    assign cwp      = cwp_q;
    assign wim      = wim_q;
    assign ovf_trap = ovf_q;
    assign unf_trap = unf_q;
    assign op_err   = err_q;
endmodule

// File: tb/tb_sparc_windowed_regfile.sv
// Bench for sparc_windowed_regfile: table-driven window-control vectors through a
// scoreboard queue, plus hand-written register, bypass, wrap and reset sequences.
module tb_sparc_windowed_regfile;
    logic        clk, rst_n;
    logic [4:0]  RA, RB, RD, RW;
    logic [31:0] PW;
    logic        LE, save, restore, cwp_we, wim_we;
    logic [2:0]  cwp_in;
    logic [7:0]  wim_in;
    logic [31:0] PA, PB, PD;
    logic [2:0]  cwp;
    logic [7:0]  wim;
    logic        ovf_trap, unf_trap, op_err;

    logic        save5, restore5, cwp_we5, wim_we5;
    logic [2:0]  cwp_in5;
    logic [4:0]  wim_in5;
    logic [31:0] PA5, PB5, PD5;
    logic [2:0]  cwp5;
    logic [4:0]  wim5;
    logic        ovf5, unf5, err5;

    int total = 0;
    int bad   = 0;

    sparc_windowed_regfile #(.DATA_W(32), .NWINDOWS(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .RA(RA), .RB(RB), .RD(RD), .RW(RW), .PW(PW), .LE(LE),
        .save(save), .restore(restore), .cwp_we(cwp_we), .cwp_in(cwp_in),
        .wim_we(wim_we), .wim_in(wim_in), .PA(PA), .PB(PB), .PD(PD), .cwp(cwp), .wim(wim),
        .ovf_trap(ovf_trap), .unf_trap(unf_trap), .op_err(op_err)
    );

    sparc_windowed_regfile #(.DATA_W(32), .NWINDOWS(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .RA(RA), .RB(RB), .RD(RD), .RW(RW), .PW(PW), .LE(LE),
        .save(save5), .restore(restore5), .cwp_we(cwp_we5), .cwp_in(cwp_in5),
        .wim_we(wim_we5), .wim_in(wim_in5), .PA(PA5), .PB(PB5), .PD(PD5), .cwp(cwp5),
        .wim(wim5), .ovf_trap(ovf5), .unf_trap(unf5), .op_err(err5)
    );

    typedef struct packed {
        logic       sv, rs, cwe;
        logic [2:0] cin;
        logic       wwe;
        logic [7:0] win;
        logic [2:0] ecwp;
        logic       eovf, eunf, eerr;
    } vec_t;

    typedef struct packed {
        logic [2:0] cwp;
        logic       ovf, unf, err;
    } exp_t;

    vec_t tbl [14];
    exp_t sb_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic ctl_idle;
        save = 0; restore = 0; cwp_we = 0; cwp_in = 0; wim_we = 0; wim_in = 0;
    endtask

    initial begin
        exp_t e;
        //           sv rs cwe cin  wwe win    ecwp ovf unf err
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'd7, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, 1'b0};

        rst_n = 0; RA = 0; RB = 0; RD = 0; RW = 0; PW = 0; LE = 0;
        ctl_idle();
        save5 = 0; restore5 = 0; cwp_we5 = 0; cwp_in5 = 0; wim_we5 = 0; wim_in5 = 0;
        #12 rst_n = 1;
        step();

        chk("rst_cwp", 64'(cwp), 64'd0);
        chk("rst_wim", 64'(wim), 64'd0);
        chk("rst_traps", 64'({ovf_trap, unf_trap, op_err}), 64'd0);
        chk("rst_r0", 64'(PA), 64'd0);

        for (int i = 0; i < 14; i++) begin
            save = tbl[i].sv; restore = tbl[i].rs; cwp_we = tbl[i].cwe; cwp_in = tbl[i].cin;
            wim_we = tbl[i].wwe; wim_in = tbl[i].win;
            sb_q.push_back('{tbl[i].ecwp, tbl[i].eovf, tbl[i].eunf, tbl[i].eerr});
            step();
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_cwp", i), 64'(cwp), 64'(e.cwp));
            chk($sformatf("vec%0d_ovf", i), 64'(ovf_trap), 64'(e.ovf));
            chk($sformatf("vec%0d_unf", i), 64'(unf_trap), 64'(e.unf));
            chk($sformatf("vec%0d_err", i), 64'(op_err), 64'(e.err));
        end
        ctl_idle();

        // r0 discards writes; globals survive window rotation
        cwp_we = 1; cwp_in = 0; step(); ctl_idle();
        LE = 1; RW = 0; PW = 32'hDEAD; RA = 0; #1;
        chk("r0_bypass", 64'(PA), 64'd0);
        step();
        chk("r0_after", 64'(PA), 64'd0);
        RW = 5; PW = 32'h55; step();
        LE = 0; save = 1; step(); ctl_idle();
        RA = 5; #1;
        chk("glob_cwp", 64'(cwp), 64'd7);
        chk("glob_r5", 64'(PA), 64'h55);

        // window overlap: outs of w2 are ins of w1; locals are private
        cwp_we = 1; cwp_in = 2; step(); ctl_idle();
        LE = 1; RW = 16; PW = 32'hBB; step();
        RW = 8; PW = 32'h1234; step();
        LE = 0; save = 1; step(); ctl_idle();
        RB = 24; #1;
        chk("ovl_cwp", 64'(cwp), 64'd1);
        chk("ovl_in24", 64'(PB), 64'h1234);
        LE = 1; RW = 16; PW = 32'hAA; step();
        LE = 0; cwp_we = 1; cwp_in = 2; step(); ctl_idle();
        RD = 16; #1;
        chk("ovl_local", 64'(PD), 64'hBB);

        // write coincident with save lands in the old window
        LE = 1; RW = 10; PW = 32'h99; save = 1; step();
        LE = 0; ctl_idle();
        RA = 26; #1;
        chk("wsave_cwp", 64'(cwp), 64'd1);
        chk("wsave_data", 64'(PA), 64'h99);

        // write bypass before the edge, then stored value after
        LE = 1; RW = 9; RA = 9; PW = 32'h77; #1;
        chk("byp_pre", 64'(PA), 64'h77);
        step();
        LE = 0; PW = 0; #1;
        chk("byp_post", 64'(PA), 64'h77);

        // five-window instance: clamp and explicit modulo wrap
        cwp_we5 = 1; cwp_in5 = 3'd6; step(); cwp_we5 = 0; cwp_in5 = 0;
        chk("w5_clamp", 64'(cwp5), 64'd4);
        restore5 = 1; step(); restore5 = 0;
        chk("w5_rs_wrap", 64'(cwp5), 64'd0);
        save5 = 1; step(); save5 = 0;
        chk("w5_sv_wrap", 64'(cwp5), 64'd4);

        // async reset clears cwp and a live trap immediately
        cwp_we = 1; cwp_in = 5; wim_we = 1; wim_in = 8'h10; step(); ctl_idle();
        save = 1; step(); ctl_idle();
        chk("pre_rst_ovf", 64'(ovf_trap), 64'd1);
        chk("pre_rst_cwp", 64'(cwp), 64'd5);
        #2 rst_n = 0; #1;
        chk("mid_rst_cwp", 64'(cwp), 64'd0);
        chk("mid_rst_traps", 64'({ovf_trap, unf_trap, op_err}), 64'd0);
        chk("mid_rst_wim", 64'(wim), 64'd0);
        #1 rst_n = 1;
        step();
        chk("post_rst_cwp", 64'(cwp), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
